// File: rtl/cpu_pkg.sv
// Shared register-file writeback types and widths.
// Purely declarative: no logic, no latency, no flow control.
package cpu_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 2;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO with registered occupancy count.
// Head is visible combinationally; push when full and pop when empty are ignored.
module wb_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_writeback_ctrl.sv
// Register file write controller: load/ALU arbitration, FIFO buffering, RAW scoreboard.
// Accept-to-write is 2 edges; sources stall only when the buffer is full, ALU also yields to loads.
module regfile_writeback_ctrl
  import cpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [ADDR_W-1:0]            alu_addr,
  input  logic [DATA_W-1:0]            alu_data,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [ADDR_W-1:0]            mem_addr,
  input  logic [DATA_W-1:0]            mem_data,
  input  logic                         rsv_valid,
  input  logic [ADDR_W-1:0]            rsv_addr,
  output logic                         rsv_ready,
  output logic [NUM_REGS-1:0]          busy,
  output logic                         rf_we,
  output logic [ADDR_W-1:0]            rf_waddr,
  output logic [DATA_W-1:0]            rf_wdata,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         sb_err
);

  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  wb_src_t       src;
  wb_entry_t     push_ent;
  wb_entry_t     head;

  logic [1:0]          cnt [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic                rsv_fire;
  logic                err_set;

  // Readiness looks only at pre-edge occupancy; a full buffer never passes through.
  assign mem_ready = !fifo_full;
  assign alu_ready = !fifo_full && !mem_valid;
  assign src       = mem_valid ? WB_MEM : WB_ALU;
  assign push      = (mem_valid && mem_ready) || (alu_valid && alu_ready);
  assign push_ent  = (src == WB_MEM) ? '{addr: mem_addr, data: mem_data}
                                     : '{addr: alu_addr, data: alu_data};
  assign pop       = !fifo_empty;

  wb_fifo #(
    .WIDTH ($bits(wb_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= pop;
      if (pop) begin
        rf_waddr <= head.addr;
        rf_wdata <= head.data;
      end
    end
  end

  assign rsv_ready = (cnt[rsv_addr] != 2'd3);
  assign rsv_fire  = rsv_valid && rsv_ready;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (rsv_fire) inc_vec[rsv_addr] = 1'b1;
    if (rf_we)    dec_vec[rf_waddr] = 1'b1;
  end

  // A commit that meets a same-edge reservation nets to zero, even from an idle count.
  assign err_set = rf_we && (cnt[rf_waddr] == 2'd0) && !inc_vec[rf_waddr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= 2'd0;
      sb_err <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc_vec[r] && !dec_vec[r])
          cnt[r] <= cnt[r] + 2'd1;
        else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != 2'd0))
          cnt[r] <= cnt[r] - 2'd1;
      end
      if (err_set) sb_err <= 1'b1;
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 0; r < NUM_REGS; r++) busy[r] = (cnt[r] != 2'd0);
  end

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Bench for regfile_writeback_ctrl: directed scenarios plus a randomized burst
// compared against a queue-based model of the writeback path and scoreboard.
module tb_regfile_writeback_ctrl;
  import cpu_pkg::*;

  localparam int FIFO_DEPTH = 4;

  logic                clk;
  logic                rst;
  logic                alu_valid, alu_ready, mem_valid, mem_ready;
  logic [ADDR_W-1:0]   alu_addr, mem_addr, rsv_addr, rf_waddr;
  logic [DATA_W-1:0]   alu_data, mem_data, rf_wdata;
  logic                rsv_valid, rsv_ready, rf_we, sb_err;
  logic [NUM_REGS-1:0] busy;
  logic [2:0]          fifo_count;

  regfile_writeback_ctrl #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready), .busy(busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fifo_count(fifo_count), .sb_err(sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: buffered results in arrival order, the write now on the port,
  // and a plain integer count of outstanding writes per register.
  wb_entry_t         q[$];
  logic              m_we;
  logic [ADDR_W-1:0] m_waddr;
  logic [DATA_W-1:0] m_wdata;
  int                m_cnt[NUM_REGS];
  logic              m_err;

  function automatic logic [NUM_REGS-1:0] exp_busy();
    logic [NUM_REGS-1:0] b;
    for (int r = 0; r < NUM_REGS; r++) b[r] = (m_cnt[r] > 0);
    return b;
  endfunction

  task automatic idle();
    alu_valid = 0; mem_valid = 0; rsv_valid = 0;
  endtask

  // Advance the model across the next edge from the inputs being driven, then step the DUT.
  task automatic tick();
    int        delta[NUM_REGS];
    bit        room;
    wb_entry_t e;
    if (rst) begin
      q.delete();
      m_we = 0; m_waddr = '0; m_wdata = '0; m_err = 0;
      for (int r = 0; r < NUM_REGS; r++) m_cnt[r] = 0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) delta[r] = 0;
      if (rsv_valid && m_cnt[rsv_addr] < 3) delta[rsv_addr] += 1;
      if (m_we) delta[m_waddr] -= 1;
      for (int r = 0; r < NUM_REGS; r++) begin
        if (delta[r] < 0 && m_cnt[r] == 0) m_err = 1;
        else m_cnt[r] += delta[r];
      end
      room = (q.size() < FIFO_DEPTH);
      if (q.size() > 0) begin
        e = q.pop_front();
        m_we = 1; m_waddr = e.addr; m_wdata = e.data;
      end else begin
        m_we = 0;
      end
      if (mem_valid && room)      q.push_back('{addr: mem_addr, data: mem_data});
      else if (alu_valid && room) q.push_back('{addr: alu_addr, data: alu_data});
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset(); tick();
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata} !== 19'd0) begin
      n_fail++; $display("FAIL reset_port: got we=%0b a=%0d d=%0h, expected 0/0/0", rf_we, rf_waddr, rf_wdata);
    end
    n_cmp++;
    if ({fifo_count, busy, sb_err} !== 8'd0) begin
      n_fail++; $display("FAIL reset_state: got cnt=%0d busy=%b err=%0b, expected all 0", fifo_count, busy, sb_err);
    end
    n_cmp++;
    if ({mem_ready, alu_ready, rsv_ready} !== 3'b111) begin
      n_fail++; $display("FAIL reset_ready: got %b, expected 111", {mem_ready, alu_ready, rsv_ready});
    end
  endtask

  task automatic test_single_alu();
    do_reset();
    rsv_valid = 1; rsv_addr = 2'd2;
    alu_valid = 1; alu_addr = 2'd2; alu_data = 16'h1234;
    tick(); idle();
    n_cmp++;
    if ({rf_we, fifo_count, busy} !== {1'b0, 3'd1, 4'b0100}) begin
      n_fail++; $display("FAIL single_E: got we=%0b cnt=%0d busy=%b, expected 0/1/0100", rf_we, fifo_count, busy);
    end
    tick();
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata, fifo_count} !== {1'b1, 2'd2, 16'h1234, 3'd0}) begin
      n_fail++; $display("FAIL single_E1: got we=%0b a=%0d d=%0h cnt=%0d, expected 1/2/1234/0", rf_we, rf_waddr, rf_wdata, fifo_count);
    end
    tick();
    n_cmp++;
    if ({rf_we, busy, sb_err} !== 6'd0) begin
      n_fail++; $display("FAIL single_E2: got we=%0b busy=%b err=%0b, expected 0/0000/0", rf_we, busy, sb_err);
    end
  endtask

  task automatic test_priority();
    mem_valid = 1; mem_addr = 2'd1; mem_data = 16'hBEEF;
    alu_valid = 1; alu_addr = 2'd3; alu_data = 16'h0005;
    #1;
    n_cmp++;
    if ({mem_ready, alu_ready} !== 2'b10) begin
      n_fail++; $display("FAIL prio_ready: got mem/alu=%b, expected 10", {mem_ready, alu_ready});
    end
    tick(); mem_valid = 0; #1;
    n_cmp++;
    if (alu_ready !== 1'b1) begin
      n_fail++; $display("FAIL prio_alu_ready: got %0b, expected 1", alu_ready);
    end
    tick(); alu_valid = 0;
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 2'd1, 16'hBEEF}) begin
      n_fail++; $display("FAIL prio_first: got we=%0b a=%0d d=%0h, expected 1/1/beef", rf_we, rf_waddr, rf_wdata);
    end
    tick();
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 2'd3, 16'h0005}) begin
      n_fail++; $display("FAIL prio_second: got we=%0b a=%0d d=%0h, expected 1/3/5", rf_we, rf_waddr, rf_wdata);
    end
    tick();
    n_cmp++;
    if (rf_we !== 1'b0) begin
      n_fail++; $display("FAIL prio_idle: got we=%0b, expected 0", rf_we);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1; alu_addr = 2'($urandom); alu_data = 16'($urandom);
      #1;
      n_cmp++;
      if (alu_ready !== (q.size() < FIFO_DEPTH)) begin
        n_fail++; $display("FAIL fill_ready[%0d]: got %0b, expected %0b", i, alu_ready, q.size() < FIFO_DEPTH);
      end
      tick();
      n_cmp++;
      if ({rf_we, rf_waddr, rf_wdata, fifo_count} !== {m_we, m_waddr, m_wdata, 3'(q.size())}) begin
        n_fail++; $display("FAIL fill_port[%0d]: got we=%0b a=%0d d=%0h cnt=%0d, expected %0b/%0d/%0h/%0d",
                           i, rf_we, rf_waddr, rf_wdata, fifo_count, m_we, m_waddr, m_wdata, q.size());
      end
    end
    idle(); tick(); tick();
    n_cmp++;
    if (fifo_count !== 3'd0) begin
      n_fail++; $display("FAIL fill_drain: got cnt=%0d, expected 0", fifo_count);
    end
  endtask

  task automatic test_back_to_back();
    bit exp_rdy;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      mem_valid = ($urandom_range(0, 2) == 0);
      alu_valid = ($urandom_range(0, 3) != 0);
      rsv_valid = ($urandom_range(0, 1) == 0);
      mem_addr = 2'($urandom); mem_data = 16'($urandom);
      alu_addr = 2'($urandom); alu_data = 16'($urandom);
      rsv_addr = 2'($urandom);
      #1;
      exp_rdy = (q.size() < FIFO_DEPTH);
      n_cmp++;
      if ({mem_ready, alu_ready, rsv_ready} !== {exp_rdy, exp_rdy && !mem_valid, m_cnt[rsv_addr] < 3}) begin
        n_fail++; $display("FAIL b2b_ready[%0d]: got mem/alu/rsv=%b, expected %b", i,
                           {mem_ready, alu_ready, rsv_ready}, {exp_rdy, exp_rdy && !mem_valid, m_cnt[rsv_addr] < 3});
      end
      tick();
      n_cmp++;
      if ({rf_we, rf_waddr, rf_wdata} !== {m_we, m_waddr, m_wdata}) begin
        n_fail++; $display("FAIL b2b_write[%0d]: got we=%0b a=%0d d=%0h, expected %0b/%0d/%0h",
                           i, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata);
      end
      n_cmp++;
      if ({fifo_count, busy, sb_err} !== {3'(q.size()), exp_busy(), m_err}) begin
        n_fail++; $display("FAIL b2b_state[%0d]: got cnt=%0d busy=%b err=%0b, expected %0d/%b/%0b",
                           i, fifo_count, busy, sb_err, q.size(), exp_busy(), m_err);
      end
    end
    idle(); tick(); tick(); tick();
    n_cmp++;
    if ({fifo_count, rf_we} !== 4'd0 || q.size() != 0) begin
      n_fail++; $display("FAIL b2b_drain: got cnt=%0d we=%0b, expected 0/0", fifo_count, rf_we);
    end
  endtask

  task automatic test_scoreboard_sat();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rsv_valid = 1; rsv_addr = 2'd1; #1;
      n_cmp++;
      if (rsv_ready !== 1'b1) begin
        n_fail++; $display("FAIL sat_rsv[%0d]: got rsv_ready=%0b, expected 1", i, rsv_ready);
      end
      tick();
    end
    #1;
    n_cmp++;
    if ({rsv_ready, busy[1]} !== 2'b01) begin
      n_fail++; $display("FAIL sat_full: got rsv_ready=%0b busy1=%0b, expected 0/1", rsv_ready, busy[1]);
    end
    rsv_addr = 2'd2; #1;
    n_cmp++;
    if (rsv_ready !== 1'b1) begin
      n_fail++; $display("FAIL sat_other: got rsv_ready=%0b for r2, expected 1", rsv_ready);
    end
    rsv_valid = 0;
    for (int k = 1; k <= 6; k++) begin
      alu_valid = (k <= 3); alu_addr = 2'd1; alu_data = 16'(k);
      tick();
      n_cmp++;
      if (busy[1] !== (k < 5)) begin
        n_fail++; $display("FAIL sat_busy[%0d]: got busy1=%0b, expected %0b", k, busy[1], k < 5);
      end
    end
    n_cmp++;
    if (sb_err !== 1'b0) begin
      n_fail++; $display("FAIL sat_err: got %0b, expected 0", sb_err);
    end
  endtask

  task automatic test_same_edge();
    do_reset();
    rsv_valid = 1; rsv_addr = 2'd0; tick();
    rsv_valid = 0; alu_valid = 1; alu_addr = 2'd0; alu_data = 16'hA5A5; tick();
    alu_valid = 0; tick();
    rsv_valid = 1; rsv_addr = 2'd0; tick();
    rsv_valid = 0;
    n_cmp++;
    if (busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL same_edge_busy: got busy0=%0b, expected 1", busy[0]);
    end
    alu_valid = 1; alu_data = 16'h5A5A; tick();
    alu_valid = 0; tick(); tick();
    n_cmp++;
    if ({busy[0], sb_err} !== 2'b00) begin
      n_fail++; $display("FAIL same_edge_after: got busy0=%0b err=%0b, expected 0/0", busy[0], sb_err);
    end
  endtask

  task automatic test_sb_err();
    do_reset();
    alu_valid = 1; alu_addr = 2'd3; alu_data = 16'h0033; tick();
    alu_valid = 0; tick();
    n_cmp++;
    if ({rf_we, sb_err} !== 2'b10) begin
      n_fail++; $display("FAIL err_before: got we=%0b err=%0b, expected 1/0", rf_we, sb_err);
    end
    tick();
    n_cmp++;
    if (sb_err !== 1'b1) begin
      n_fail++; $display("FAIL err_set: got %0b, expected 1", sb_err);
    end
    tick(); tick(); tick();
    n_cmp++;
    if (sb_err !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: got %0b, expected 1", sb_err);
    end
  endtask

  task automatic test_mid_reset();
    rsv_valid = 1; rsv_addr = 2'd2;
    alu_valid = 1; alu_addr = 2'd2; alu_data = 16'h7777; tick();
    rsv_valid = 0; alu_addr = 2'd1; alu_data = 16'h8888; tick();
    rst = 1; tick();
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata, fifo_count, busy, sb_err} !== 27'd0) begin
      n_fail++; $display("FAIL midrst_state: got we=%0b a=%0d d=%0h cnt=%0d busy=%b err=%0b, expected all 0",
                         rf_we, rf_waddr, rf_wdata, fifo_count, busy, sb_err);
    end
    rst = 0; idle();
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({rf_we, fifo_count} !== 4'd0) begin
        n_fail++; $display("FAIL midrst_after[%0d]: got we=%0b cnt=%0d, expected 0/0", i, rf_we, fifo_count);
      end
    end
  endtask

  initial begin
    rst = 1; idle();
    alu_addr = '0; alu_data = '0; mem_addr = '0; mem_data = '0; rsv_addr = '0;
    test_reset();
    test_single_alu();
    test_priority();
    test_fill();
    test_back_to_back();
    test_scoreboard_sat();
    test_same_edge();
    test_sb_err();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
